pc_predictor: RTL
=================

Name: pc_predictor

Overview:
- Parametrised successor of the fetch-stage next-PC generator.
- Adds gshare direction prediction with a configurable counter table, global history and counter width.
- Adds a return-address stack (RAS) for JAL call / JALR return pairs, plus a misprediction counter.
- Sits between the fetcher and the branch-resolution forwarding path. Drives next PC, rollback PC and the global rollback strobe.

Parameters:
- XLEN, 32, data/address width.
- INDEX_BITS, 6, log2 of counter-table entries; the table is indexed by pc[INDEX_BITS+1:2].
- HISTORY_BITS, 4, global history length. Legal range 0..INDEX_BITS; 0 gives a pure bimodal predictor.
- COUNTER_BITS, 2, saturating counter width, >=1.
- RAS_DEPTH, 4, return-stack entries, >=1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- ena  in  1  global enable for PC/RAS state.
- in_fetcher_ena  in  1  in_last_pc/in_last_inst valid this cycle.
- in_last_pc  in  XLEN  PC of the fetched instruction.
- in_last_inst  in  32  fetched instruction.
- out_next_pc  out  XLEN  registered next fetch PC.
- out_next_taken  out  1  registered; 1 if out_next_pc is a predicted redirect.
- out_pred_index  out  INDEX_BITS  registered table index used for the prediction. The pipeline carries it with the branch.
- in_forwarding_ena  in  1  a branch resolved this cycle.
- in_forwarding_index  in  INDEX_BITS  index returned with the resolved branch.
- in_forwarding_branch_taken  in  1  resolved direction.
- in_misbranch  in  1  the resolved branch was mispredicted.
- in_forwarding_correct_address  in  XLEN  correct target.
- out_rollback  out  1  combinational copy of in_misbranch.
- out_rollback_pc  out  XLEN  combinational copy of in_forwarding_correct_address.
- out_mispredict_count  out  32  saturating count of misbranch cycles.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_next_pc=0, out_next_taken=0, out_pred_index=0.
  - history=0, RAS count=0, out_mispredict_count=0.
  - Every counter = 1<<(COUNTER_BITS-1), i.e. weakly taken.
- Reset asserted mid-operation aborts any update immediately. No partial update survives.
- Prediction index: idx = pc[INDEX_BITS+1:2] XOR zero-extended history.
- Priority each clk edge, when ena=1:
  - in_misbranch: out_next_pc <= in_forwarding_correct_address; out_next_taken <= in_forwarding_branch_taken; RAS cleared (count=0).
  - Else, if in_fetcher_ena, decode by opcode:
    - BRANCH: taken = counter[idx] MSB. out_next_pc <= taken ? pc+B_IMM : pc+4. out_pred_index <= idx.
    - JAL: out_next_pc <= pc+J_IMM, out_next_taken <= 1. If rd is x1 or x5, push pc+4 onto the RAS.
    - JALR with rd=x0 and rs1 in {x1,x5} (return): if RAS not empty, pop, out_next_pc <= top, taken=1. If empty, pc+4, taken=0.
    - Any other opcode, including other JALR forms: pc+4, taken=0.
  - Else: hold state.
- ena=0: PC, RAS and out_pred_index hold.
- RAS: circular buffer.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - No simultaneous push and pop is possible (single instruction per cycle).
- Table/history update runs independent of ena, on in_forwarding_ena:
  - counter[in_forwarding_index] increments on taken, saturating at all-ones.
  - It decrements on not-taken, saturating at 0.
  - history <= {history[HISTORY_BITS-2:0], taken}. History is committed, non-speculative.
- Same-cycle read and update of one entry: the prediction uses the pre-update value.
- out_mispredict_count increments on each edge with in_misbranch=1 and ena=1, saturating at 0xFFFFFFFF.
- Address arithmetic: all adds modulo 2^XLEN. B_IMM and J_IMM are sign-extended to XLEN.

Test Plan:
- Reset: drive rst=0 mid-run with in_fetcher_ena=1 -> all outputs 0 immediately, without waiting for clk; after release, first BRANCH at pc=0x100 with imm=+16 predicts 0x110, taken=1.
- Saturation: 3 not-taken resolves on index 5 -> counter 0; a 4th not-taken leaves it 0; BRANCH mapping to idx 5 at pc=0x200 -> 0x204, taken=0.
- Gshare: HISTORY_BITS=4, history=4'b0011 after resolves; BRANCH at pc=0x40 -> out_pred_index = 0x10^0x3 = 0x13.
- RAS: JAL rd=x1 at 0x1000 then return JALR at 0x2000 -> next PC 0x1004. Five calls with depth 4, then four returns -> returns 4..1 correct. Fifth return with RAS empty -> pc+4, taken=0.
- Rollback priority: in_misbranch=1 and a JAL fetched in the same cycle, correct address 0x3000 -> out_next_pc=0x3000, out_rollback=1, RAS empty, out_mispredict_count +1.
- ena=0 with in_forwarding_ena=1 -> PC holds, counter still updates, mispredict count unchanged.

Source files
------------

// File: rtl/pc_predictor.sv
// Fetch-stage next-PC generator: gshare direction prediction, return-address stack for
// call/return pairs, branch-resolution rollback and a saturating mispredict counter.
module pc_predictor #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned INDEX_BITS   = 6,
  parameter int unsigned HISTORY_BITS = 4,
  parameter int unsigned COUNTER_BITS = 2,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  in_fetcher_ena,
  input  logic [XLEN-1:0]       in_last_pc,
  input  logic [31:0]           in_last_inst,
  output logic [XLEN-1:0]       out_next_pc,
  output logic                  out_next_taken,
  output logic [INDEX_BITS-1:0] out_pred_index,
  input  logic                  in_forwarding_ena,
  input  logic [INDEX_BITS-1:0] in_forwarding_index,
  input  logic                  in_forwarding_branch_taken,
  input  logic                  in_misbranch,
  input  logic [XLEN-1:0]       in_forwarding_correct_address,
  output logic                  out_rollback,
  output logic [XLEN-1:0]       out_rollback_pc,
  output logic [31:0]           out_mispredict_count
);

  localparam int unsigned Entries = 1 << INDEX_BITS;
  localparam int unsigned HistW   = (HISTORY_BITS > 0) ? HISTORY_BITS : 1;
  localparam int unsigned PtrW    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(RAS_DEPTH + 1);

  localparam logic [COUNTER_BITS-1:0] CtrInit = COUNTER_BITS'(1 << (COUNTER_BITS - 1));
  localparam logic [COUNTER_BITS-1:0] CtrMax  = '1;
  localparam logic [PtrW-1:0]         PtrLast = PtrW'(RAS_DEPTH - 1);
  localparam logic [CntW-1:0]         CntFull = CntW'(RAS_DEPTH);

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  logic [XLEN-1:0]         pc_q, pc_d;
  logic                    taken_q, taken_d;
  logic [INDEX_BITS-1:0]   idx_q, idx_d;
  logic [HistW-1:0]        hist_q;
  logic [COUNTER_BITS-1:0] ctr_q [Entries];
  logic [XLEN-1:0]         ras_q [RAS_DEPTH];
  logic [PtrW-1:0]         ras_ptr_q;
  logic [CntW-1:0]         ras_cnt_q;
  logic [31:0]             mcnt_q;

  logic [6:0]            opcode;
  logic [4:0]            rd, rs1;
  logic [XLEN-1:0]       b_imm, j_imm, pc_plus4;
  logic [INDEX_BITS-1:0] hist_ext, pred_idx;
  logic                  ctr_taken, link_rd, is_ret;
  logic [PtrW-1:0]       ptr_next, ptr_prev;
  logic                  ras_push, ras_pop, ras_clear;

  assign opcode   = in_last_inst[6:0];
  assign rd       = in_last_inst[11:7];
  assign rs1      = in_last_inst[19:15];
  assign b_imm    = {{(XLEN-12){in_last_inst[31]}}, in_last_inst[7], in_last_inst[30:25],
                     in_last_inst[11:8], 1'b0};
  assign j_imm    = {{(XLEN-20){in_last_inst[31]}}, in_last_inst[19:12], in_last_inst[20],
                     in_last_inst[30:21], 1'b0};
  assign pc_plus4 = in_last_pc + XLEN'(4);

  // With zero history bits the one-bit hist_q is never folded into the index.
  assign hist_ext  = (HISTORY_BITS == 0) ? '0 : INDEX_BITS'(hist_q);
  assign pred_idx  = in_last_pc[INDEX_BITS+1:2] ^ hist_ext;
  assign ctr_taken = ctr_q[pred_idx][COUNTER_BITS-1];

  assign link_rd = (rd == 5'd1) || (rd == 5'd5);
  assign is_ret  = (opcode == OpJalr) && (rd == 5'd0) && ((rs1 == 5'd1) || (rs1 == 5'd5));

  assign ptr_next = (ras_ptr_q == PtrLast) ? '0 : ras_ptr_q + PtrW'(1);
  assign ptr_prev = (ras_ptr_q == '0) ? PtrLast : ras_ptr_q - PtrW'(1);

  assign out_next_pc          = pc_q;
  assign out_next_taken       = taken_q;
  assign out_pred_index       = idx_q;
  assign out_rollback         = in_misbranch;
  assign out_rollback_pc      = in_forwarding_correct_address;
  assign out_mispredict_count = mcnt_q;

  always_comb begin
    pc_d      = pc_q;
    taken_d   = taken_q;
    idx_d     = idx_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = 1'b0;
    if (ena) begin
      if (in_misbranch) begin
        pc_d      = in_forwarding_correct_address;
        taken_d   = in_forwarding_branch_taken;
        ras_clear = 1'b1;
      end else if (in_fetcher_ena) begin
        case (opcode)
          OpBranch: begin
            taken_d = ctr_taken;
            pc_d    = ctr_taken ? in_last_pc + b_imm : pc_plus4;
            idx_d   = pred_idx;
          end
          OpJal: begin
            pc_d     = in_last_pc + j_imm;
            taken_d  = 1'b1;
            ras_push = link_rd;
          end
          default: begin
            if (is_ret && (ras_cnt_q != '0)) begin
              pc_d    = ras_q[ptr_prev];
              taken_d = 1'b1;
              ras_pop = 1'b1;
            end else begin
              pc_d    = pc_plus4;
              taken_d = 1'b0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      taken_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      idx_q   <= idx_d;
    end
  end

  // Circular stack: a push when full overwrites the oldest slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else if (ras_clear) begin
      ras_cnt_q <= '0;
    end else if (ras_push) begin
      ras_q[ras_ptr_q] <= pc_plus4;
      ras_ptr_q        <= ptr_next;
      if (ras_cnt_q != CntFull) ras_cnt_q <= ras_cnt_q + CntW'(1);
    end else if (ras_pop) begin
      ras_ptr_q <= ptr_prev;
      ras_cnt_q <= ras_cnt_q - CntW'(1);
    end
  end

  // Table and history train on resolved branches regardless of ena.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      for (int i = 0; i < Entries; i++) ctr_q[i] <= CtrInit;
    end else if (in_forwarding_ena) begin
      hist_q <= HistW'({hist_q, in_forwarding_branch_taken});
      if (in_forwarding_branch_taken) begin
        if (ctr_q[in_forwarding_index] != CtrMax) begin
          ctr_q[in_forwarding_index] <= ctr_q[in_forwarding_index] + COUNTER_BITS'(1);
        end
      end else if (ctr_q[in_forwarding_index] != '0) begin
        ctr_q[in_forwarding_index] <= ctr_q[in_forwarding_index] - COUNTER_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt_q <= '0;
    end else if (ena && in_misbranch && (mcnt_q != 32'hFFFF_FFFF)) begin
      mcnt_q <= mcnt_q + 32'd1;
    end
  end

endmodule
